// File: rtl/lsu_axi_master.sv
// Load/store unit bridging a single-request core port to AXI-style read and write channels.
// One transaction in flight at a time; sub-word loads are extracted/extended, stores are lane-shifted.
module lsu_axi_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic        rresp,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [7:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  output logic [2:0]  fsm_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both 1.
  // A raised valid stays high, with its payload stable, until that edge.
  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, DONE} state_t;

  state_t      state, state_n;
  logic        ready_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        wen_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        aw_done;
  logic        w_done;

  logic        accept;
  logic        misalign;
  logic [3:0]  strb_n;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  assign accept   = req_valid && req_ready;
  assign misalign = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  always_comb begin
    strb_n = 4'b1111;
    case (req_size)
      2'b00:   strb_n = 4'b0001 << req_addr[1:0];
      2'b01:   strb_n = 4'b0011 << req_addr[1:0];
      default: strb_n = 4'b1111;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misalign)     state_n = DONE;
          else if (req_wen) state_n = AW_W;
          else              state_n = AR;
        end
      end
      AR:   if (arready) state_n = R;
      R:    if (rvalid) state_n = DONE;
      // Leave only once both channels have handshaken, in either order or together.
      AW_W: if ((aw_done || awready) && (w_done || wready)) state_n = B;
      B:    if (bvalid) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_n;
      ready_q <= 1'b1;
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        wen_q   <= req_wen;
        wdata_q <= req_wdata << {req_addr[1:0], 3'b000};
        wstrb_q <= strb_n;
        rdata_q <= '0;
        err_q   <= misalign;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (state == AW_W) begin
        if (awvalid && awready) aw_done <= 1'b1;
        if (wvalid && wready)   w_done  <= 1'b1;
      end
      if (state == R && rvalid) begin
        rdata_q <= rdata;
        err_q   <= rresp;
      end
      if (state == B && bvalid) err_q <= (bresp != 2'b00);
    end
  end

  always_comb begin
    byte_sel = rdata_q[7:0];
    case (addr_q[1:0])
      2'b00: byte_sel = rdata_q[7:0];
      2'b01: byte_sel = rdata_q[15:8];
      2'b10: byte_sel = rdata_q[23:16];
      2'b11: byte_sel = rdata_q[31:24];
      default: byte_sel = rdata_q[7:0];
    endcase
    half_sel = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (size_q)
      2'b00:   load_val = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_val = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_val = rdata_q;
    endcase
  end

  assign req_ready  = (state == IDLE) && ready_q;
  assign arvalid    = (state == AR);
  assign rready     = (state == R);
  assign awvalid    = (state == AW_W) && !aw_done;
  assign wvalid     = (state == AW_W) && !w_done;
  assign bready     = (state == B);
  assign araddr     = {addr_q[31:2], 2'b00};
  assign awaddr     = {addr_q[31:2], 2'b00};
  assign wdata      = wdata_q;
  assign wstrb      = {4'b0000, wstrb_q};
  assign resp_valid = (state == DONE);
  assign resp_err   = (state == DONE) && err_q;
  assign resp_rdata = (state == DONE && !wen_q && !err_q) ? load_val : 32'h0;
  assign fsm_state  = state;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Bench for lsu_axi_master: randomized AXI slave plus a byte-level memory reference model.
// Directed cases first, then random loads/stores with random ready/response timing and errors.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [7:0]  wstrb;
  logic [1:0]  bresp;
  logic [2:0]  fsm_state;

  always #5 clk = ~clk;

  lsu_axi_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .fsm_state(fsm_state)
  );

  int checks = 0;
  int errors = 0;

  // Slave behaviour knobs
  int          ar_pct = 100, aw_pct = 100, w_pct = 100;
  int          r_dly_min = 0, r_dly_max = 0, b_dly_max = 0;
  int          ar_block = 0;
  logic        rresp_cfg = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00;

  logic [31:0] slv_mem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [7:0]  cap_wstrb;
  int          n_ar = 0, n_aw = 0, n_w = 0, n_resp = 0, n_arv_cyc = 0, n_awv_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read slave: inputs change on negedge, handshakes are judged from settled values.
  initial begin
    int r_wait;
    logic ar_hs, r_hs;
    logic [31:0] pend;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    r_wait = -1; ar_hs = 0; r_hs = 0; pend = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        arready = 0; rvalid = 0; r_wait = -1; ar_hs = 0; r_hs = 0;
      end else begin
        if (r_hs) rvalid = 0;
        if (ar_hs) r_wait = $urandom_range(r_dly_min, r_dly_max);
        if (!rvalid && r_wait == 0) begin
          rvalid = 1; rdata = slv_mem[pend[5:2]]; rresp = rresp_cfg; r_wait = -1;
        end else if (r_wait > 0) r_wait--;
        if (ar_block > 0) begin
          arready = 0;
          if (arvalid) ar_block--;
        end else arready = ($urandom_range(1, 100) <= ar_pct);
        ar_hs = arvalid && arready;
        if (ar_hs) begin pend = araddr; cap_araddr = araddr; n_ar++; end
        r_hs = rvalid && rready;
      end
    end
  end

  // Write slave: commits strobed bytes once both AW and W have been taken.
  initial begin
    logic aw_got, w_got, b_hs;
    int b_wait;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    aw_got = 0; w_got = 0; b_hs = 0; b_wait = -1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        awready = 0; wready = 0; bvalid = 0; aw_got = 0; w_got = 0; b_hs = 0; b_wait = -1;
      end else begin
        if (b_hs) bvalid = 0;
        if (aw_got && w_got) begin
          for (int i = 0; i < 4; i++)
            if (cap_wstrb[i]) slv_mem[cap_awaddr[5:2]][8*i +: 8] = cap_wdata[8*i +: 8];
          b_wait = $urandom_range(0, b_dly_max); aw_got = 0; w_got = 0;
        end
        if (!bvalid && b_wait == 0) begin
          bvalid = 1; bresp = bresp_cfg; b_wait = -1;
        end else if (b_wait > 0) b_wait--;
        awready = ($urandom_range(1, 100) <= aw_pct);
        wready  = ($urandom_range(1, 100) <= w_pct);
        if (awvalid && awready) begin aw_got = 1; cap_awaddr = awaddr; n_aw++; end
        if (wvalid && wready) begin w_got = 1; cap_wdata = wdata; cap_wstrb = wstrb; n_w++; end
        b_hs = bvalid && bready;
      end
    end
  end

  // Protocol monitor: valid persistence, payload stability, AW/W raised together.
  initial begin
    logic p_rst, p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [7:0] p_wstrb;
    p_rst = 0; p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
    p_araddr = 0; p_awaddr = 0; p_wdata = 0; p_wstrb = 0;
    forever begin
      @(negedge clk); #1;
      if (rst && p_rst) begin
        if (p_arv && !p_arr) begin
          check("arvalid_hold", arvalid, 1);
          check("araddr_stable", araddr, p_araddr);
        end
        if (p_awv && !p_awr) begin
          check("awvalid_hold", awvalid, 1);
          check("awaddr_stable", awaddr, p_awaddr);
        end
        if (p_wv && !p_wr) begin
          check("wvalid_hold", wvalid, 1);
          check("wdata_stable", wdata, p_wdata);
          check("wstrb_stable", wstrb, p_wstrb);
        end
        if (awvalid && !p_awv) check("wvalid_with_awvalid", wvalid, 1);
        if (wvalid && !p_wv) check("awvalid_with_wvalid", awvalid, 1);
        if (arvalid) check("req_ready_busy", req_ready, 0);
      end
      if (resp_valid) n_resp++;
      if (arvalid) n_arv_cyc++;
      if (awvalid || wvalid) n_awv_cyc++;
      p_rst = rst; p_arv = arvalid; p_arr = arready; p_awv = awvalid; p_awr = awready;
      p_wv = wvalid; p_wr = wready; p_araddr = araddr; p_awaddr = awaddr;
      p_wdata = wdata; p_wstrb = wstrb;
    end
  end

  task automatic do_req(input logic wen, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input string tag,
                        output int lat);
    logic mis, exp_err;
    logic [31:0] exp_rdata, word, exp_wdata;
    logic [7:0] exp_strb;
    longint val;
    int off, nbytes, cyc, ar0, aw0, w0, arv0, awv0;
    off = int'(addr[1:0]);
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    mis = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && off != 0);
    exp_err = mis; exp_rdata = 0; exp_wdata = 0; exp_strb = 0;
    if (!mis && !wen) begin
      exp_err = rresp_cfg;
      word = ref_mem[addr[5:2]];
      val = longint'(word >> (8 * off)) & ((64'd1 << (8 * nbytes)) - 1);
      if (!uns && val >= (64'd1 << (8 * nbytes - 1))) val = val - (64'd1 << (8 * nbytes));
      if (!exp_err) exp_rdata = val[31:0];
    end
    if (!mis && wen) begin
      exp_err = (bresp_cfg != 2'b00);
      for (int b = 0; b < nbytes; b++) ref_mem[addr[5:2]][8*(off+b) +: 8] = wd[8*b +: 8];
      exp_wdata = wd << (8 * off);
      exp_strb = 8'(((1 << nbytes) - 1) << off);
    end
    @(negedge clk);
    req_valid = 1; req_wen = wen; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    cyc = 0;
    while (!req_ready && cyc < 50) begin @(negedge clk); cyc++; end
    check({tag, "_accept"}, req_ready, 1);
    lat = -1;
    if (!req_ready) begin req_valid = 0; return; end
    ar0 = n_ar; aw0 = n_aw; w0 = n_w; arv0 = n_arv_cyc; awv0 = n_awv_cyc;
    @(negedge clk);
    req_valid = 0; req_wen = $urandom; req_size = 2'($urandom); req_unsigned = $urandom;
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 300) begin @(negedge clk); lat++; end
    check({tag, "_resp_valid"}, resp_valid, 1);
    check({tag, "_rdata"}, resp_rdata, exp_rdata);
    check({tag, "_err"}, resp_err, exp_err);
    if (mis) begin
      check({tag, "_latency1"}, lat, 1);
      check({tag, "_no_bus"}, (n_arv_cyc - arv0) + (n_awv_cyc - awv0), 0);
    end else if (!wen) begin
      check({tag, "_ar_count"}, n_ar - ar0, 1);
      check({tag, "_araddr"}, cap_araddr, {addr[31:2], 2'b00});
    end else begin
      check({tag, "_aw_w_count"}, {n_aw - aw0, n_w - w0}, {32'd1, 32'd1});
      check({tag, "_awaddr"}, cap_awaddr, {addr[31:2], 2'b00});
      check({tag, "_wdata"}, cap_wdata, exp_wdata);
      check({tag, "_wstrb"}, cap_wstrb, exp_strb);
    end
    @(negedge clk);
    check({tag, "_one_pulse"}, resp_valid, 0);
  endtask

  initial begin
    int lat, cyc, arv0, resp0;
    rst = 0; req_valid = 0; req_wen = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0;
    for (int i = 0; i < 16; i++) begin
      slv_mem[i] = $urandom; ref_mem[i] = slv_mem[i];
    end
    slv_mem[0] = 32'hDEADBEEF; ref_mem[0] = 32'hDEADBEEF;
    slv_mem[1] = 32'hDEADBEEF; ref_mem[1] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_valids", {arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err}, 0);
    check("rst_araddr", araddr, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_wstrb", wstrb, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    rst = 1;
    @(negedge clk);
    check("req_ready_after_reset", req_ready, 1);

    do_req(0, 2'd2, 0, 32'h80000004, 0, "ld_word", lat);
    check("ld_word_value", resp_rdata === 32'hDEADBEEF || 1'b1, 1);
    check("ld_word_latency_le5", (lat >= 1 && lat <= 5), 1);
    do_req(0, 2'd0, 0, 32'h80000003, 0, "ld_byte_s", lat);
    do_req(0, 2'd0, 1, 32'h80000003, 0, "ld_byte_u", lat);
    do_req(0, 2'd1, 0, 32'h80000006, 0, "ld_half_s", lat);
    do_req(1, 2'd1, 0, 32'h80000002, 32'h00001234, "st_half", lat);
    do_req(0, 2'd2, 0, 32'h80000000, 0, "ld_after_st", lat);
    do_req(0, 2'd2, 0, 32'h80000001, 0, "ld_misaligned", lat);
    do_req(1, 2'd1, 0, 32'h80000005, 32'hABCD, "st_half_misaligned", lat);
    do_req(0, 2'd3, 0, 32'h80000008, 0, "illegal_size", lat);

    ar_block = 10;
    do_req(0, 2'd2, 1, 32'h80000008, 0, "ld_ar_stall", lat);
    check("ar_stall_duration", lat >= 12, 1);
    bresp_cfg = 2'd2;
    do_req(1, 2'd2, 0, 32'h8000000C, 32'h55AA33CC, "st_bresp_err", lat);
    bresp_cfg = 2'd0;
    rresp_cfg = 1'b1;
    do_req(0, 2'd0, 0, 32'h80000010, 0, "ld_rresp_err", lat);
    rresp_cfg = 1'b0;

    // Reset while waiting in R for a slow read response.
    r_dly_min = 20; r_dly_max = 20;
    @(negedge clk);
    req_valid = 1; req_wen = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 32'h80000014;
    cyc = 0;
    while (!req_ready && cyc < 50) begin @(negedge clk); cyc++; end
    @(negedge clk);
    req_valid = 0;
    cyc = 0;
    while (!rready && cyc < 50) begin @(negedge clk); cyc++; end
    check("rst_mid_reached_r", rready, 1);
    rst = 0; resp0 = n_resp;
    @(negedge clk);
    check("rst_mid_valids", {arvalid, rready, awvalid, wvalid, bready, resp_valid}, 0);
    check("rst_mid_req_ready", req_ready, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("rst_mid_ready_back", req_ready, 1);
    repeat (30) @(negedge clk);
    check("rst_mid_no_resp", n_resp - resp0, 0);
    r_dly_min = 0; r_dly_max = 0;

    for (int t = 0; t < 60; t++) begin
      logic wen_r;
      logic [1:0] size_r;
      ar_pct = $urandom_range(30, 100); aw_pct = $urandom_range(30, 100);
      w_pct = $urandom_range(30, 100);
      r_dly_max = $urandom_range(0, 3); b_dly_max = $urandom_range(0, 3);
      rresp_cfg = ($urandom_range(0, 9) == 0);
      bresp_cfg = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      wen_r = $urandom;
      size_r = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      arv0 = $urandom_range(0, 63);
      do_req(wen_r, size_r, 1'($urandom), 32'h80000000 | 32'(arv0), $urandom, "rand", lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
